// File: rtl/pipelined_idex_stage.sv
// rtl/pipelined_idex_stage.sv - ID/EX pipeline register with forwarding, operand muxing and load-use detection
//
// Ports:
//   CLK, Reset           clock (rising edge), synchronous active-high reset
//   ID_*                 decoded operands, register numbers and control from the ID stage
//   Stall, Flush         hold all registers / load a bubble
//   EXMEM_*, MEMWB_*     forwarding sources from the later pipeline stages
//   BusA, BusB, ALUCtrl  ALU operands and operation
//   StoreData            forwarded rt value for stores
//   DstReg               write-back register number
//   EX_*                 registered downstream control
//   LoadUseStall         combinational load-use hazard; upstream must hold while high
module pipelined_idex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [DATA_W-1:0] ID_RsData,
  input  logic [DATA_W-1:0] ID_RtData,
  input  logic [15:0]       ID_Imm16,
  input  logic [REG_W-1:0]  ID_Shamt,
  input  logic [REG_W-1:0]  ID_Rs,
  input  logic [REG_W-1:0]  ID_Rt,
  input  logic [REG_W-1:0]  ID_Rd,
  input  logic              ID_UsesRt,
  input  logic [3:0]        ID_ALUCtrl,
  input  logic              ID_ALUSrc,
  input  logic              ID_ExtOp,
  input  logic              ID_ShiftImm,
  input  logic              ID_RegDst,
  input  logic              ID_RegWrite,
  input  logic              ID_MemRead,
  input  logic              ID_MemWrite,
  input  logic              ID_MemToReg,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              EXMEM_RegWrite,
  input  logic [REG_W-1:0]  EXMEM_Rd,
  input  logic [DATA_W-1:0] EXMEM_Result,
  input  logic              MEMWB_RegWrite,
  input  logic [REG_W-1:0]  MEMWB_Rd,
  input  logic [DATA_W-1:0] MEMWB_Result,
  output logic [DATA_W-1:0] BusA,
  output logic [DATA_W-1:0] BusB,
  output logic [3:0]        ALUCtrl,
  output logic [DATA_W-1:0] StoreData,
  output logic [REG_W-1:0]  DstReg,
  output logic              EX_RegWrite,
  output logic              EX_MemRead,
  output logic              EX_MemWrite,
  output logic              EX_MemToReg,
  output logic              LoadUseStall
);

  logic [DATA_W-1:0] rs_data_q;
  logic [DATA_W-1:0] rt_data_q;
  logic [15:0]       imm_q;
  logic [REG_W-1:0]  shamt_q;
  logic [REG_W-1:0]  rs_q;
  logic [REG_W-1:0]  rt_q;
  logic [REG_W-1:0]  rd_q;
  logic [3:0]        alu_ctrl_q;
  logic              alu_src_q;
  logic              ext_op_q;
  logic              shift_imm_q;
  logic              reg_dst_q;
  logic              reg_write_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic              mem_to_reg_q;

  // A bubble is an all-zero register set, identical to reset, so both share one branch.
  always_ff @(posedge CLK) begin
    if (Reset || Flush || LoadUseStall) begin
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_q        <= '0;
      shamt_q      <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      rd_q         <= '0;
      alu_ctrl_q   <= '0;
      alu_src_q    <= 1'b0;
      ext_op_q     <= 1'b0;
      shift_imm_q  <= 1'b0;
      reg_dst_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
    end else if (!Stall) begin
      rs_data_q    <= ID_RsData;
      rt_data_q    <= ID_RtData;
      imm_q        <= ID_Imm16;
      shamt_q      <= ID_Shamt;
      rs_q         <= ID_Rs;
      rt_q         <= ID_Rt;
      rd_q         <= ID_Rd;
      alu_ctrl_q   <= ID_ALUCtrl;
      alu_src_q    <= ID_ALUSrc;
      ext_op_q     <= ID_ExtOp;
      shift_imm_q  <= ID_ShiftImm;
      reg_dst_q    <= ID_RegDst;
      reg_write_q  <= ID_RegWrite;
      mem_read_q   <= ID_MemRead;
      mem_write_q  <= ID_MemWrite;
      mem_to_reg_q <= ID_MemToReg;
    end
  end

  // Forwarding hits: the younger EX/MEM result beats MEM/WB; register 0 never forwards.
  logic exmem_rs_hit, memwb_rs_hit, exmem_rt_hit, memwb_rt_hit;
  logic [DATA_W-1:0] fwd_rs, fwd_rt, ext_imm;

  assign exmem_rs_hit = EXMEM_RegWrite && (EXMEM_Rd != '0) && (EXMEM_Rd == rs_q);
  assign memwb_rs_hit = MEMWB_RegWrite && (MEMWB_Rd != '0) && (MEMWB_Rd == rs_q);
  assign exmem_rt_hit = EXMEM_RegWrite && (EXMEM_Rd != '0) && (EXMEM_Rd == rt_q);
  assign memwb_rt_hit = MEMWB_RegWrite && (MEMWB_Rd != '0) && (MEMWB_Rd == rt_q);

  assign fwd_rs = exmem_rs_hit ? EXMEM_Result : (memwb_rs_hit ? MEMWB_Result : rs_data_q);
  assign fwd_rt = exmem_rt_hit ? EXMEM_Result : (memwb_rt_hit ? MEMWB_Result : rt_data_q);

  // LUI relies on zero extension here; the ALU does the upper-half shift.
  assign ext_imm = ext_op_q ? {{(DATA_W-16){imm_q[15]}}, imm_q} : {{(DATA_W-16){1'b0}}, imm_q};

  assign BusA        = shift_imm_q ? DATA_W'(shamt_q) : fwd_rs;
  assign BusB        = alu_src_q ? ext_imm : fwd_rt;
  assign StoreData   = fwd_rt;
  assign ALUCtrl     = alu_ctrl_q;
  assign DstReg      = reg_dst_q ? rd_q : rt_q;
  assign EX_RegWrite = reg_write_q;
  assign EX_MemRead  = mem_read_q;
  assign EX_MemWrite = mem_write_q;
  assign EX_MemToReg = mem_to_reg_q;

  // A load in EX whose target is read by the instruction in ID; the bubble it
  // inserts clears mem_read_q, so the hazard lasts exactly one cycle.
  assign LoadUseStall = mem_read_q && (rt_q != '0) &&
                        ((rt_q == ID_Rs) || (ID_UsesRt && (rt_q == ID_Rt)));

endmodule

// File: doc/pipelined_idex_stage.md
Name: pipelined_idex_stage

Overview:
ID/EX pipeline register plus execute-side operand selection for the pipelined MIPS core. Captures decoded operands and control from the ID stage and resolves EX/MEM and MEM/WB forwarding. Drives BusA, BusB and ALUCtrl of the pipelined ALU directly. Detects load-use hazards and inserts a bubble.

Parameters:
DATA_W, 32, datapath width
REG_W, 5, register-number width

Ports:
CLK  in  1  clock, rising edge
Reset  in  1  synchronous, active-high
ID_RsData  in  32  rs register-file read value
ID_RtData  in  32  rt register-file read value
ID_Imm16  in  16  instruction immediate
ID_Shamt  in  5  instruction shamt field
ID_Rs, ID_Rt, ID_Rd  in  5 each  register numbers
ID_UsesRt  in  1  instruction in ID reads rt as a source
ID_ALUCtrl  in  4  ALU operation code
ID_ALUSrc  in  1  BusB = extended immediate
ID_ExtOp  in  1  1 = sign-extend, 0 = zero-extend
ID_ShiftImm  in  1  BusA = shamt (sll/srl/sra)
ID_RegDst  in  1  1 = destination rd, 0 = rt
ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg  in  1 each  downstream control
Stall  in  1  hold all registers
Flush  in  1  load a bubble
EXMEM_RegWrite  in  1  |  EXMEM_Rd  in  5  |  EXMEM_Result  in  32  EX/MEM forwarding source
MEMWB_RegWrite  in  1  |  MEMWB_Rd  in  5  |  MEMWB_Result  in  32  MEM/WB forwarding source
BusA  out  32  ALU operand A
BusB  out  32  ALU operand B
ALUCtrl  out  4  ALU operation
StoreData  out  32  forwarded rt value for sw
DstReg  out  5  write-back register number
EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg  out  1 each  registered control
LoadUseStall  out  1  combinational; ID/IF must hold when 1

Behaviour:
- All ID_* fields are registered on the rising CLK edge. Register update priority: Reset > (Flush | LoadUseStall) > Stall > load.
- Reset clears every register to 0. Resulting outputs: ALUCtrl=0 (AND), all EX_* control=0, DstReg=0, BusA=BusB=StoreData=0, LoadUseStall=0.
- Bubble: all registers cleared to 0, exactly as reset. A bubble is never written back and never accesses memory.
- Stall without bubble: every register holds its value. Flush and LoadUseStall both override Stall.
- Latency: one cycle from ID inputs to registered outputs. Forwarding, muxing and extension are combinational from registered fields.
- Forwarding, operand X ∈ {rs, rt}; priority order, first match wins:
  - EXMEM_RegWrite & EXMEM_Rd≠0 & EXMEM_Rd==X_q → EXMEM_Result.
  - else MEMWB_RegWrite & MEMWB_Rd≠0 & MEMWB_Rd==X_q → MEMWB_Result.
  - else the registered register-file value.
  - Register 0 is never forwarded.
- BusA = ShiftImm_q ? {27'b0, Shamt_q} : fwdRs.
- BusB = ALUSrc_q ? ext(Imm_q) : fwdRt.
  - ext with ExtOp_q=1 → {16{Imm[15]}, Imm}; ExtOp_q=0 → {16'b0, Imm}.
  - LUI uses ExtOp=0; the ALU performs the shift.
- StoreData = fwdRt, independent of ALUSrc.
- DstReg = RegDst_q ? Rd_q : Rt_q.
- LoadUseStall = EX_MemRead & Rt_q≠0 & (Rt_q==ID_Rs | (ID_UsesRt & Rt_q==ID_Rt)).
  - When asserted, the next edge loads a bubble while upstream holds. The hazard therefore clears after exactly one bubble cycle.
- Reset asserted mid-stall clears state; LoadUseStall drops the same cycle because EX_MemRead=0.

Test Plan:
- Reset: hold Reset high 2 cycles with arbitrary ID inputs → all outputs 0, LoadUseStall=0.
- Forward priority: rs_q=5; EXMEM(RegWrite=1, Rd=5, Result=0x11); MEMWB(RegWrite=1, Rd=5, Result=0x22) → BusA=0x11. Drop EXMEM_RegWrite → BusA=0x22. Set both Rd=0 → BusA=ID_RsData.
- Immediate path: ALUSrc=1, ExtOp=1, Imm=0x8000 → BusB=0xFFFF8000. ExtOp=0 → BusB=0x00008000. ShiftImm=1, Shamt=7 → BusA=7.
- Load-use: lw to r8 in EX, ID has Rs=8 → LoadUseStall=1. Next cycle is a bubble (EX_RegWrite=0, EX_MemWrite=0, DstReg=0) and LoadUseStall=0. Repeat with ID_Rt=8, UsesRt=0 → no stall. Repeat with Rt_q=0 → no stall.
- Stall/Flush: Stall=1 for 3 cycles with changing ID inputs → outputs frozen. Stall=1 & Flush=1 → bubble loaded.
- Store forwarding: sw with ALUSrc=1, Rt_q=9, MEMWB(RegWrite=1, Rd=9, Result=0xDEADBEEF) → StoreData=0xDEADBEEF, BusB=ext(Imm).
